// File: rtl/rv_emu_retire_cmp_pkg.sv
// Shared types for the emulator-vs-CPU retire comparator: record layout,
// per-field compare enables and the field-wise difference function.
package RV_EMU_params_pkg;

    typedef enum logic [2:0] {
        IT_ALU,
        IT_LOAD,
        IT_STORE,
        IT_BRANCH,
        IT_JUMP,
        IT_CSR,
        IT_SYSTEM,
        _internal_error_
    } INSTR_TYPE;

    localparam int NUM_CHECKS = 15;
    typedef logic [NUM_CHECKS-1:0] CHECKS;

    localparam int CHK_PC          = 0;
    localparam int CHK_RS1_RD      = 1;
    localparam int CHK_RS1_ADDR    = 2;
    localparam int CHK_RS2_RD      = 3;
    localparam int CHK_RS2_ADDR    = 4;
    localparam int CHK_GPR_WR      = 5;
    localparam int CHK_GPR_ADDR    = 6;
    localparam int CHK_GPR_DATA    = 7;
    localparam int CHK_CSR_WR      = 8;
    localparam int CHK_CSR_WR_DATA = 9;
    localparam int CHK_CSR_RD      = 10;
    localparam int CHK_CSR_RD_DATA = 11;
    localparam int CHK_EXC         = 12;
    localparam int CHK_EVENTS      = 13;
    localparam int CHK_MODE        = 14;

    typedef struct packed {
        logic        valid;
        logic [4:0]  cause;
        logic [31:0] tval;
        logic [31:0] epc;
    } EXC_INFO;

    typedef struct packed {
        logic [31:0] pc;
        logic        rs1_rd;
        logic [4:0]  rs1_addr;
        logic        rs2_rd;
        logic [4:0]  rs2_addr;
        logic        gpr_wr;
        logic [4:0]  gpr_addr;
        logic [31:0] gpr_data;
        logic        csr_wr;
        logic [31:0] csr_wr_data;
        logic        csr_rd;
        logic [31:0] csr_rd_data;
        EXC_INFO     exc;
        logic [7:0]  events;
        logic [1:0]  mode;
        INSTR_TYPE   itype;
    } RETIRE_REC;

    typedef struct packed {
        RETIRE_REC rec;
        CHECKS     chk;
    } FIFO_ENTRY;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } CMP_STATE;

    // Unmasked per-field difference; exception tval/epc only matter when the
    // emulator actually took an exception.
    function automatic CHECKS rec_diff(input RETIRE_REC emu, input RETIRE_REC cpu);
        CHECKS d;
        d                  = '0;
        d[CHK_PC]          = emu.pc != cpu.pc;
        d[CHK_RS1_RD]      = emu.rs1_rd != cpu.rs1_rd;
        d[CHK_RS1_ADDR]    = emu.rs1_addr != cpu.rs1_addr;
        d[CHK_RS2_RD]      = emu.rs2_rd != cpu.rs2_rd;
        d[CHK_RS2_ADDR]    = emu.rs2_addr != cpu.rs2_addr;
        d[CHK_GPR_WR]      = emu.gpr_wr != cpu.gpr_wr;
        d[CHK_GPR_ADDR]    = emu.gpr_addr != cpu.gpr_addr;
        d[CHK_GPR_DATA]    = emu.gpr_data != cpu.gpr_data;
        d[CHK_CSR_WR]      = emu.csr_wr != cpu.csr_wr;
        d[CHK_CSR_WR_DATA] = emu.csr_wr_data != cpu.csr_wr_data;
        d[CHK_CSR_RD]      = emu.csr_rd != cpu.csr_rd;
        d[CHK_CSR_RD_DATA] = emu.csr_rd_data != cpu.csr_rd_data;
        d[CHK_EXC]         = (emu.exc.valid != cpu.exc.valid) ||
                             (emu.exc.cause != cpu.exc.cause) ||
                             (emu.exc.valid && ((emu.exc.tval != cpu.exc.tval) ||
                                                (emu.exc.epc != cpu.exc.epc)));
        d[CHK_EVENTS]      = emu.events != cpu.events;
        d[CHK_MODE]        = emu.mode != cpu.mode;
        return d;
    endfunction

endpackage

// File: rtl/rv_emu_rec_fifo.sv
// Synchronous FIFO of emulator retire records plus their compare enables.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rv_emu_rec_fifo
    import RV_EMU_params_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_in,
    input  logic      reset_in,
    input  logic      push,
    input  FIFO_ENTRY push_data,
    input  logic      pop,
    output FIFO_ENTRY head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    FIFO_ENTRY      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which slots hold live data, so clearing the array buys nothing.
    always_ff @(posedge clk_in) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rv_emu_retire_cmp.sv
// Lock-step retire comparator: buffers emulator retire records and checks
// each CPU retirement against the oldest one, with error counters and halt.
module rv_emu_retire_cmp
    import RV_EMU_params_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int HALT_ON_ERR = 1
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        emu_valid,
    output logic        emu_ready,
    input  RETIRE_REC   emu_rec,
    input  CHECKS       emu_chk,
    input  logic        cpu_valid,
    input  RETIRE_REC   cpu_rec,
    output logic        mismatch,
    output CHECKS       mismatch_mask,
    output INSTR_TYPE   mismatch_itype,
    output logic [31:0] match_cnt,
    output logic [15:0] err_cnt,
    output logic        underflow,
    output logic        timeout,
    output logic        halted
);

    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    CMP_STATE  state;
    CMP_STATE  state_next;
    FIFO_ENTRY head;
    logic      full;
    logic      empty;
    logic      run;
    logic      push;
    logic      pop;
    logic      udf_evt;
    CHECKS     cmp_mask;
    logic      cmp_fail;
    logic      idle_count;
    logic      idle_hit;
    logic      err_evt;
    logic [IW-1:0] idle_cnt;

    rv_emu_rec_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .push      (push),
        .push_data ({emu_rec, emu_chk}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign run       = (state == ST_RUN);
    assign emu_ready = run && !full;
    assign push      = emu_valid && emu_ready;
    assign pop       = run && cpu_valid && !empty;
    assign udf_evt   = run && cpu_valid && empty;
    assign cmp_mask  = rec_diff(head.rec, cpu_rec) & head.chk;
    assign cmp_fail  = (cmp_mask != '0);

    assign idle_count = run && !empty && !cpu_valid;
    assign idle_hit   = idle_count && (idle_cnt == IW'(TIMEOUT_CYC - 1));
    assign err_evt    = (pop && cmp_fail) || udf_evt || idle_hit;
    assign halted     = (state == ST_HALT);

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is given a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (state == ST_RUN && HALT_ON_ERR != 0 && err_evt) begin
            state_next = ST_HALT;
        end
    end

    // Saturates at TIMEOUT_CYC so the timeout edge fires exactly once.
    always_ff @(posedge clk_in) begin
        if (reset_in || !idle_count) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(TIMEOUT_CYC)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mismatch       <= 1'b0;
            mismatch_mask  <= '0;
            mismatch_itype <= _internal_error_;
            match_cnt      <= '0;
            err_cnt        <= '0;
            underflow      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            mismatch <= pop && cmp_fail;
            if (pop) begin
                mismatch_mask <= cmp_mask;
                if (cmp_fail) begin
                    mismatch_itype <= head.rec.itype;
                end
            end
            if (pop && !cmp_fail && match_cnt != '1) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (((pop && cmp_fail) || udf_evt) && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end
            if (idle_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_emu_retire_cmp.sv
// Self-checking bench: queue-based reference model predicts each compare
// result into a scoreboard that an independent monitor drains.
module tb_rv_emu_retire_cmp;
    import RV_EMU_params_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk_in;
    logic        reset_in;
    logic        emu_valid;
    logic        emu_ready;
    RETIRE_REC   emu_rec;
    CHECKS       emu_chk;
    logic        cpu_valid;
    RETIRE_REC   cpu_rec;
    logic        mismatch;
    CHECKS       mismatch_mask;
    INSTR_TYPE   mismatch_itype;
    logic [31:0] match_cnt;
    logic [15:0] err_cnt;
    logic        underflow;
    logic        timeout;
    logic        halted;

    rv_emu_retire_cmp #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYC    (TMO),
        .HALT_ON_ERR    (1)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .emu_valid      (emu_valid),
        .emu_ready      (emu_ready),
        .emu_rec        (emu_rec),
        .emu_chk        (emu_chk),
        .cpu_valid      (cpu_valid),
        .cpu_rec        (cpu_rec),
        .mismatch       (mismatch),
        .mismatch_mask  (mismatch_mask),
        .mismatch_itype (mismatch_itype),
        .match_cnt      (match_cnt),
        .err_cnt        (err_cnt),
        .underflow      (underflow),
        .timeout        (timeout),
        .halted         (halted)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        RETIRE_REC rec;
        CHECKS     chk;
    } ent_t;

    typedef struct {
        bit        mm;
        CHECKS     mask;
        INSTR_TYPE itype;
        int        mc;
        int        ec;
    } exp_t;

    // Model state: what the DUT should show after the next clock edge.
    ent_t      mq[$];
    exp_t      sb[$];
    bit        m_halted;
    bit        m_udf;
    bit        m_tmo;
    int        m_idle;
    int        m_mc;
    int        m_ec;
    CHECKS     m_mask;
    INSTR_TYPE m_itype;

    // Which enabled fields differ, straight from the field-compare rules.
    function automatic CHECKS model_mask(input RETIRE_REC e, input RETIRE_REC c, input CHECKS en);
        CHECKS bad;
        bit    exc_bad;
        exc_bad = (e.exc.valid != c.exc.valid) || (e.exc.cause != c.exc.cause);
        if (e.exc.valid && (e.exc.tval != c.exc.tval || e.exc.epc != c.exc.epc)) exc_bad = 1;
        bad = {e.mode != c.mode, e.events != c.events, exc_bad,
               e.csr_rd_data != c.csr_rd_data, e.csr_rd != c.csr_rd,
               e.csr_wr_data != c.csr_wr_data, e.csr_wr != c.csr_wr,
               e.gpr_data != c.gpr_data, e.gpr_addr != c.gpr_addr, e.gpr_wr != c.gpr_wr,
               e.rs2_addr != c.rs2_addr, e.rs2_rd != c.rs2_rd,
               e.rs1_addr != c.rs1_addr, e.rs1_rd != c.rs1_rd, e.pc != c.pc};
        return bad & en;
    endfunction

    function automatic RETIRE_REC rand_rec();
        RETIRE_REC r;
        r.pc          = $urandom;
        r.rs1_rd      = 1'($urandom);
        r.rs1_addr    = 5'($urandom);
        r.rs2_rd      = 1'($urandom);
        r.rs2_addr    = 5'($urandom);
        r.gpr_wr      = 1'($urandom);
        r.gpr_addr    = 5'($urandom);
        r.gpr_data    = $urandom;
        r.csr_wr      = 1'($urandom);
        r.csr_wr_data = $urandom;
        r.csr_rd      = 1'($urandom);
        r.csr_rd_data = $urandom;
        r.exc.valid   = 1'($urandom);
        r.exc.cause   = 5'($urandom);
        r.exc.tval    = $urandom;
        r.exc.epc     = $urandom;
        r.events      = 8'($urandom);
        r.mode        = 2'($urandom);
        r.itype       = INSTR_TYPE'(3'($urandom_range(0, 6)));
        return r;
    endfunction

    function automatic RETIRE_REC perturb(input RETIRE_REC r, input int k);
        RETIRE_REC p;
        p = r;
        case (k)
            0:  p.pc          = p.pc ^ 32'h4;
            1:  p.rs1_rd      = ~p.rs1_rd;
            2:  p.rs1_addr    = p.rs1_addr ^ 5'h1;
            3:  p.rs2_rd      = ~p.rs2_rd;
            4:  p.rs2_addr    = p.rs2_addr ^ 5'h2;
            5:  p.gpr_wr      = ~p.gpr_wr;
            6:  p.gpr_addr    = p.gpr_addr ^ 5'h4;
            7:  p.gpr_data    = p.gpr_data ^ 32'h1;
            8:  p.csr_wr      = ~p.csr_wr;
            9:  p.csr_wr_data = p.csr_wr_data ^ 32'h100;
            10: p.csr_rd      = ~p.csr_rd;
            11: p.csr_rd_data = p.csr_rd_data ^ 32'h8;
            12: if ($urandom_range(0, 1) == 0) p.exc.cause = p.exc.cause ^ 5'h1;
                else p.exc.tval = p.exc.tval ^ 32'h10;
            13: p.events      = p.events ^ 8'h80;
            default: p.mode   = p.mode ^ 2'h1;
        endcase
        return p;
    endfunction

    // One cycle: called at a negedge, drives inputs, advances the model,
    // returns at the following negedge.
    task automatic step(input bit ev, input RETIRE_REC er, input CHECKS ec,
                        input bit cv, input RETIRE_REC cr);
        bit    ready;
        bit    fail;
        bit    udf;
        bit    tmo_now;
        int    size0;
        ent_t  h;
        exp_t  e;
        CHECKS mk;
        size0 = mq.size();
        ready = !m_halted && size0 < DEPTH;
        check("emu_ready", emu_ready, ready);
        emu_valid = ev;
        emu_rec   = er;
        emu_chk   = ec;
        cpu_valid = cv;
        cpu_rec   = cr;
        fail      = 0;
        udf       = !m_halted && cv && size0 == 0;
        tmo_now   = 0;
        if (!m_halted && cv && size0 > 0) begin
            h      = mq.pop_front();
            mk     = model_mask(h.rec, cr, h.chk);
            fail   = (mk != '0);
            m_mask = mk;
            if (fail) begin
                m_itype = h.rec.itype;
                m_ec++;
            end else begin
                m_mc++;
            end
            e = '{fail, m_mask, m_itype, m_mc, m_ec};
            sb.push_back(e);
        end
        if (udf) begin
            m_udf = 1;
            m_ec++;
            e = '{1'b0, m_mask, m_itype, m_mc, m_ec};
            sb.push_back(e);
        end
        if (!m_halted && size0 > 0 && !cv) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_tmo   = 1;
                tmo_now = 1;
            end
        end else begin
            m_idle = 0;
        end
        if (fail || udf || tmo_now) m_halted = 1;
        if (ev && ready) begin
            h.rec = er;
            h.chk = ec;
            mq.push_back(h);
        end
        @(negedge clk_in);
    endtask

    task automatic idle();
        step(0, '0, '0, 0, '0);
    endtask

    task automatic push_only(input RETIRE_REC r, input CHECKS c);
        step(1, r, c, 0, '0);
    endtask

    task automatic cpu_only(input RETIRE_REC r);
        step(0, '0, '0, 1, r);
    endtask

    // Reset is held with traffic on both inputs so a compare in flight at
    // the reset edge must be discarded.
    task automatic do_reset();
        reset_in  = 1;
        emu_valid = 1;
        emu_rec   = rand_rec();
        emu_chk   = '1;
        cpu_valid = 1;
        cpu_rec   = rand_rec();
        repeat (2) @(negedge clk_in);
        reset_in  = 0;
        emu_valid = 0;
        cpu_valid = 0;
        check("sb_drained_before_reset", sb.size(), 0);
        sb.delete();
        mq.delete();
        m_halted = 0;
        m_udf    = 0;
        m_tmo    = 0;
        m_idle   = 0;
        m_mc     = 0;
        m_ec     = 0;
        m_mask   = '0;
        m_itype  = _internal_error_;
        check("rst_emu_ready", emu_ready, 1);
        check("rst_mismatch", mismatch, 0);
        check("rst_mask", mismatch_mask, 0);
        check("rst_itype", mismatch_itype, _internal_error_);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_underflow", underflow, 0);
        check("rst_timeout", timeout, 0);
        check("rst_halted", halted, 0);
    endtask

    // Monitor: any compare/underflow result shows up as a counter change or
    // a mismatch pulse; each one consumes one scoreboard entry.
    int prev_mc = 0;
    int prev_ec = 0;
    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (reset_in) begin
            prev_mc = 0;
            prev_ec = 0;
        end else begin
            if (mismatch || int'(match_cnt) != prev_mc || int'(err_cnt) != prev_ec) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: mismatch=%0b match_cnt=%0d err_cnt=%0d with no result expected",
                             mismatch, match_cnt, err_cnt);
                end else begin
                    e = sb.pop_front();
                    check("sb_mismatch", mismatch, e.mm);
                    check("sb_mask", mismatch_mask, e.mask);
                    check("sb_itype", mismatch_itype, e.itype);
                    check("sb_match_cnt", match_cnt, e.mc);
                    check("sb_err_cnt", err_cnt, e.ec);
                end
            end
            prev_mc = int'(match_cnt);
            prev_ec = int'(err_cnt);
            check("mon_underflow", underflow, m_udf);
            check("mon_timeout", timeout, m_tmo);
            check("mon_halted", halted, m_halted);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    RETIRE_REC b;
    RETIRE_REC x;
    RETIRE_REC q4 [4];
    CHECKS     c_base;

    initial begin
        reset_in  = 1;
        emu_valid = 0;
        cpu_valid = 0;
        emu_rec   = '0;
        cpu_rec   = '0;
        emu_chk   = '0;
        do_reset();

        b          = '0;
        b.pc       = 32'h100;
        b.gpr_wr   = 1;
        b.gpr_addr = 5;
        b.gpr_data = 32'h1234;
        b.itype    = IT_LOAD;
        c_base     = '0;
        c_base[CHK_PC]       = 1;
        c_base[CHK_GPR_WR]   = 1;
        c_base[CHK_GPR_ADDR] = 1;
        c_base[CHK_GPR_DATA] = 1;

        // Exact match.
        push_only(b, c_base);
        cpu_only(b);
        check("match_cnt_after_match", match_cnt, 1);
        check("no_mismatch_after_match", mismatch, 0);

        // Data mismatch halts and later cpu_valid is ignored.
        do_reset();
        push_only(b, c_base);
        x = b;
        x.gpr_data = 32'h1235;
        cpu_only(x);
        check("data_mm_pulse", mismatch, 1);
        check("data_mm_mask", mismatch_mask, 15'(1) << CHK_GPR_DATA);
        check("data_mm_itype", mismatch_itype, IT_LOAD);
        check("data_mm_err_cnt", err_cnt, 1);
        check("data_mm_halted", halted, 1);
        repeat (3) cpu_only(b);
        check("data_mm_pulse_one_cycle", mismatch, 0);
        check("halt_err_frozen", err_cnt, 1);
        check("halt_match_frozen", match_cnt, 0);
        check("halt_no_underflow", underflow, 0);

        // Unchecked fields may differ; tval only matters with an exception.
        do_reset();
        x = b;
        x.csr_wr_data = 32'hAAAA;
        push_only(x, c_base);
        x.csr_wr_data = 32'h5555;
        cpu_only(x);
        x = b;
        x.exc.tval = 32'h77;
        push_only(x, c_base | (15'(1) << CHK_EXC));
        x.exc.tval = 32'h99;
        cpu_only(x);
        push_only(rand_rec(), '0);
        cpu_only(rand_rec());
        check("masked_match_cnt", match_cnt, 3);
        check("masked_err_cnt", err_cnt, 0);

        // Full FIFO: no push admitted while full, even alongside a pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q4[i]    = rand_rec();
            q4[i].pc = 32'h200 + 32'(4 * i);
            push_only(q4[i], '1);
        end
        check("full_ready_low", emu_ready, 0);
        step(1, rand_rec(), '1, 1, q4[0]);
        check("ready_after_pop", emu_ready, 1);
        for (int i = 1; i < 4; i++) cpu_only(q4[i]);
        check("inorder_match_cnt", match_cnt, 4);
        check("inorder_err_cnt", err_cnt, 0);

        // Underflow.
        do_reset();
        cpu_only(b);
        check("udf_flag", underflow, 1);
        check("udf_err_cnt", err_cnt, 1);
        check("udf_halted", halted, 1);
        check("udf_no_pulse", mismatch, 0);

        // Timeout boundary, then reset recovers.
        do_reset();
        push_only(b, c_base);
        repeat (TMO - 1) idle();
        check("tmo_not_yet", timeout, 0);
        idle();
        check("tmo_flag", timeout, 1);
        check("tmo_halted", halted, 1);
        do_reset();

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            int pev;
            int pcv;
            do_reset();
            pev = int'($urandom_range(30, 90));
            pcv = int'($urandom_range(20, 90));
            for (int cyc = 0; cyc < 60; cyc++) begin
                bit        ev;
                bit        cv;
                CHECKS     ec;
                RETIRE_REC cr;
                ev = int'($urandom_range(0, 99)) < pev;
                cv = int'($urandom_range(0, 99)) < pcv;
                ec = ($urandom_range(0, 7) == 0) ? CHECKS'(0) : CHECKS'($urandom);
                cr = (mq.size() > 0) ? mq[0].rec : rand_rec();
                if ($urandom_range(0, 3) == 0) cr = perturb(cr, int'($urandom_range(0, 14)));
                step(ev, rand_rec(), ec, cv, cr);
            end
        end

        idle();
        idle();
        check("sb_drained_at_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
